// File: rtl/mm_axis_packer.sv
// Packs D_W_ACC-bit result elements into AXIS_W-bit AXI-Stream beats, with
// TLAST/TKEEP framing per M*N2-element matrix and an upstream in_last cross-check.
module mm_axis_packer #(
  parameter int M       = 8,
  parameter int N2      = 8,
  parameter int D_W_ACC = 16,
  parameter int AXIS_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [D_W_ACC-1:0]    in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [AXIS_W-1:0]     m_axis_tdata,
  output logic [AXIS_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_done,
  output logic                  err_last
);

  localparam int K      = AXIS_W / D_W_ACC;
  localparam int FRAME  = M * N2;
  localparam int BPL    = D_W_ACC / 8;
  localparam int KEEP_W = AXIS_W / 8;
  localparam int LANE_W = (K > 1) ? $clog2(K) : 1;
  localparam int IDX_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(K - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME - 1);

  if ((AXIS_W % D_W_ACC) != 0 || (D_W_ACC % 8) != 0 || FRAME < 1) begin : g_param_check
    $error("mm_axis_packer: illegal parameters AXIS_W=%0d D_W_ACC=%0d FRAME=%0d",
           AXIS_W, D_W_ACC, FRAME);
  end

  logic [LANE_W-1:0] lane;
  logic [IDX_W-1:0]  elem_idx;
  logic [AXIS_W-1:0] pack;
  logic [AXIS_W-1:0] beat_data;
  logic [KEEP_W-1:0] beat_keep;
  logic              frame_end;
  logic              completes;
  logic              accept;
  logic              out_hs;

  assign frame_end = (elem_idx == LAST_IDX);
  assign completes = (lane == LAST_LANE) || frame_end;

  // Valid/ready: a transfer happens on a rising edge where valid && ready; a
  // producer never withdraws valid or changes payload until that transfer.
  // in_ready only falls when this element would need the output register
  // while it still holds an unaccepted beat.
  assign in_ready = !completes || !m_axis_tvalid || m_axis_tready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = m_axis_tvalid && m_axis_tready;

  // Lanes below the current one come from the pack register, the current lane
  // is the incoming element, lanes above are zero with their keep bytes clear.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int j = 0; j < K; j++) begin
      if (LANE_W'(j) < lane) begin
        beat_data[j*D_W_ACC +: D_W_ACC] = pack[j*D_W_ACC +: D_W_ACC];
      end else if (LANE_W'(j) == lane) begin
        beat_data[j*D_W_ACC +: D_W_ACC] = in_data;
      end
      if (LANE_W'(j) <= lane) begin
        beat_keep[j*BPL +: BPL] = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      elem_idx <= '0;
      pack     <= '0;
    end else if (accept) begin
      elem_idx <= frame_end ? '0 : elem_idx + 1'b1;
      if (completes) begin
        lane <= '0;
      end else begin
        lane <= lane + 1'b1;
        for (int j = 0; j < K; j++) begin
          if (LANE_W'(j) == lane) begin
            pack[j*D_W_ACC +: D_W_ACC] <= in_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      err_last      <= 1'b0;
    end else begin
      frame_done <= out_hs && m_axis_tlast;
      if (accept && completes) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data;
        m_axis_tkeep  <= beat_keep;
        m_axis_tlast  <= frame_end;
      end else if (out_hs) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept && (in_last != frame_end)) begin
        err_last <= 1'b1;
      end
    end
  end

endmodule
